// File: rtl/scan_index_gen.sv
`default_nettype none
// scan_index_gen: steps a 3-bit row select through the enabled rows, holding each for dwell+1 cycles.
// Define SCAN_ROW_MASK_EN to add the row_mask input, which skips rows whose mask bit is set.
module scan_index_gen #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_ROW_MASK_EN
  input  logic [7:0]         row_mask,
`endif
  output logic [2:0]         sel,
  output logic               sel_vld,
  output logic               row_done,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } t_state;

  t_state             r_state, w_state_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [7:0]         r_mask, w_mask_nxt;
  logic               r_stop_pend, w_stop_pend_nxt;
  logic [7:0]         w_mask_in;
  logic [7:0]         w_en_cur;
  logic [7:0]         w_en_new;
  logic               w_row_end;
  logic               w_frame_end;

`ifdef SCAN_ROW_MASK_EN
  assign w_mask_in = row_mask;
`else
  assign w_mask_in = 8'h00;
`endif

  function automatic logic [2:0] f_lowest(input logic [7:0] en);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (en[i]) res = 3'(i);
    end
    return res;
  endfunction

  function automatic logic [2:0] f_highest(input logic [7:0] en);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) res = 3'(i);
    end
    return res;
  endfunction

  // Smallest enabled index above cur; falls back to the lowest enabled one (wrap).
  function automatic logic [2:0] f_next(input logic [7:0] en, input logic [2:0] cur);
    logic [2:0] res;
    res = f_lowest(en);
    for (int i = 7; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) res = 3'(i);
    end
    return res;
  endfunction

  assign w_en_cur    = ~r_mask;
  assign w_en_new    = ~w_mask_in;
  assign w_row_end   = (r_state == S_SCAN) && (r_cnt == '0);
  assign w_frame_end = w_row_end && (r_sel == f_highest(w_en_cur));

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    w_dwell_nxt     = r_dwell;
    w_mask_nxt      = r_mask;
    w_stop_pend_nxt = r_stop_pend;
    case (r_state)
      S_IDLE: begin
        if (start && !stop && (|w_en_new)) begin
          w_state_nxt = S_SCAN;
          w_dwell_nxt = dwell;
          w_mask_nxt  = w_mask_in;
          w_sel_nxt   = f_lowest(w_en_new);
          w_cnt_nxt   = dwell;
        end
      end
      S_SCAN: begin
        if (stop) w_stop_pend_nxt = 1'b1;
        if (w_row_end) begin
          // A stop arriving in the final cycle of a row still halts at this row end.
          if (r_stop_pend || stop || (w_frame_end && !(|w_en_new))) begin
            w_state_nxt     = S_IDLE;
            w_sel_nxt       = 3'd0;
            w_cnt_nxt       = '0;
            w_stop_pend_nxt = 1'b0;
          end else if (w_frame_end) begin
            w_dwell_nxt = dwell;
            w_mask_nxt  = w_mask_in;
            w_sel_nxt   = f_lowest(w_en_new);
            w_cnt_nxt   = dwell;
          end else begin
            w_sel_nxt = f_next(w_en_cur, r_sel);
            w_cnt_nxt = r_dwell;
          end
        end else begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 3'd0;
      r_cnt       <= '0;
      r_dwell     <= '0;
      r_mask      <= 8'h00;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dwell     <= w_dwell_nxt;
      r_mask      <= w_mask_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  assign sel        = r_sel;
  assign sel_vld    = (r_state == S_SCAN);
  assign busy       = (r_state == S_SCAN);
  assign row_done   = w_row_end;
  assign frame_done = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_scan_index_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_scan_index_gen
// Brief   : Scoreboard bench for scan_index_gen; a frame-planning model queues
//           expected outputs per cycle and a monitor compares them.
// Rev     : 1.1
// ============================================================================
module tb_scan_index_gen;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [7:0]    row_mask = 8'h00;
    logic [2:0]    sel;
    logic          sel_vld;
    logic          row_done;
    logic          frame_done;
    logic          busy;

    scan_index_gen #(.DWELL_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .dwell      (dwell),
`ifdef SCAN_ROW_MASK_EN
        .row_mask   (row_mask),
`endif
        .sel        (sel),
        .sel_vld    (sel_vld),
        .row_done   (row_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       rd;
        logic       fd;
    } ent_t;

    ent_t       mq[$];
    logic [6:0] sb_q[$];
    bit         m_scan = 1'b0;
    bit         m_stop = 1'b0;
    int         m_dwell = 0;
    logic [7:0] m_mask = 8'h00;
    ent_t       m_ended;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;

    task automatic plan_frame();
        int hi;
        hi = 0;
        for (int r = 0; r < 8; r++) if (!m_mask[r]) hi = r;
        for (int r = 0; r < 8; r++) begin
            if (!m_mask[r]) begin
                for (int c = 0; c <= m_dwell; c++) begin
                    mq.push_back('{sel: 3'(r), rd: (c == m_dwell), fd: (c == m_dwell) && (r == hi)});
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_scan = 1'b0;
            m_stop = 1'b0;
            mq.delete();
        end else if (!m_scan) begin
            if (start && !stop && (row_mask != 8'hFF)) begin
                m_scan  = 1'b1;
                m_dwell = int'(dwell);
                m_mask  = row_mask;
                plan_frame();
            end
        end else begin
            m_ended = mq.pop_front();
            if (stop) m_stop = 1'b1;
            if (m_ended.rd) begin
                if (m_stop) begin
                    m_scan = 1'b0;
                    m_stop = 1'b0;
                    mq.delete();
                end else if (m_ended.fd) begin
                    if (row_mask == 8'hFF) begin
                        m_scan = 1'b0;
                    end else begin
                        m_dwell = int'(dwell);
                        m_mask  = row_mask;
                        plan_frame();
                    end
                end
            end
        end
        if (m_scan) sb_q.push_back({2'b11, mq[0].sel, mq[0].rd, mq[0].fd});
        else        sb_q.push_back(7'b0);
    end

    always @(negedge clk) begin
        logic [6:0] exp_v;
        logic [6:0] act_v;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            act_v = {busy, sel_vld, sel, row_done, frame_done};
            n_chk = n_chk + 1;
            if (act_v === exp_v) n_pass = n_pass + 1;
            else $display("FAIL outputs cycle %0d: got busy/vld/sel/rd/fd=%b/%b/%0d/%b/%b expected %b/%b/%0d/%b/%b",
                          cyc, act_v[6], act_v[5], act_v[4:2], act_v[1], act_v[0],
                          exp_v[6], exp_v[5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        logic [6:0] act_v;
        act_v = {busy, sel_vld, sel, row_done, frame_done};
        n_chk = n_chk + 1;
        if (act_v === 7'b0) n_pass = n_pass + 1;
        else $display("FAIL reset state (%s): got busy/vld/sel/rd/fd=%b/%b/%0d/%b/%b expected all zero",
                      tag, act_v[6], act_v[5], act_v[4:2], act_v[1], act_v[0]);
    endtask

    task automatic wait_frame_done(input int limit);
        int k;
        k = 0;
        while ((frame_done !== 1'b1) && (k < limit)) begin
            tick();
            k = k + 1;
        end
        n_chk = n_chk + 1;
        if (frame_done === 1'b1) n_pass = n_pass + 1;
        else $display("FAIL wait expired: no frame_done within %0d cycles", limit);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        repeat (3) tick();
        check_reset_state("initial");
        rst_n = 1'b1;
        repeat (3) tick();

        dwell = 8'd3;
        pulse_start();
        wait_frame_done(40);
        repeat (70) tick();
        halt();

        dwell = 8'd0;
        pulse_start();
        repeat (20) tick();
        halt();

        dwell = 8'd3;
        pulse_start();
        repeat (21) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (12) tick();

        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();

        pulse_start();
        repeat (13) tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check_reset_state("mid-row");
        repeat (3) tick();
        pulse_start();
        repeat (10) tick();
        halt();

        dwell = 8'd3;
        pulse_start();
        repeat (10) tick();
        dwell = 8'd1;
        repeat (45) tick();
        halt();

        dwell = 8'hFF;
        pulse_start();
        repeat (2060) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SCAN_ROW_MASK_EN
        dwell    = 8'd1;
        row_mask = 8'b1010_1010;
        pulse_start();
        repeat (20) tick();
        halt();
        row_mask = 8'hFF;
        pulse_start();
        repeat (5) tick();
        row_mask = 8'h0F;
        dwell    = 8'd0;
        pulse_start();
        row_mask = 8'hFF;
        repeat (10) tick();
        row_mask = 8'h00;
`endif

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 29) == 0) dwell = DW'($urandom_range(0, 5));
`ifdef SCAN_ROW_MASK_EN
            if ($urandom_range(0, 39) == 0) row_mask = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
`endif
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_index_gen.md
SCAN_INDEX_GEN -- requirements
Module: scan_index_gen

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, the width of the dwell count.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, which begins continuous scanning when sampled high in IDLE.
REQ-005 SHALL have port stop, input, 1, which requests a halt at the end of the current row.
REQ-006 SHALL have port dwell, input, DWELL_W, giving the cycles per row minus one.
REQ-007 SHALL have port row_mask, input, 8, where bit i=1 skips row i (present only under REQ-025).
REQ-008 SHALL have port sel, output, 3, the row index that feeds the downstream 3-to-8 one-hot decoder.
REQ-009 SHALL have port sel_vld, output, 1, high while sel is a live scan index.
REQ-010 SHALL have port row_done, output, 1, a one-cycle pulse in the final cycle of each row.
REQ-011 SHALL have port frame_done, output, 1, a one-cycle pulse in the final cycle of the last enabled row of a frame.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE and SCAN, with a registered stop_pend flag.
- IDLE to SCAN: start=1 and stop=0 and at least one row is enabled.
- SCAN to IDLE: at the row end when stop_pend=1.
REQ-014 SHALL, in IDLE with start=1 at edge k, latch dwell and the mask; from cycle k+1, sel = lowest enabled index, sel_vld=1, busy=1.
REQ-015 SHALL hold each sel value for exactly dwell+1 cycles, using a down-counter loaded with the latched dwell and rolling over at 0.
- dwell=0 gives one cycle per row.
- dwell=2^DWELL_W-1 is legal.
REQ-016 SHALL assert row_done during the cycle in which the counter equals 0, and in no other cycle.
REQ-017 SHALL advance sel on the cycle after row_done to the next enabled index in ascending order, wrapping from the highest enabled index to the lowest.
- The wrap runs 7 to 0 with no mask.
REQ-018 SHALL assert frame_done coincident with row_done of the highest enabled index.
REQ-019 SHALL re-sample dwell and the mask only at a frame boundary (the cycle after frame_done); changes mid-frame have no effect.
REQ-020 SHALL set stop_pend when stop=1 in SCAN.
- The current row completes, including its row_done and any frame_done pulse.
- In the next cycle: IDLE, sel=0, sel_vld=0, busy=0, stop_pend cleared.
REQ-021 SHALL treat start asserted in SCAN as having no effect, and start and stop together in IDLE as no start (stop wins).
REQ-022 SHALL drive sel=0 and sel_vld=0 in IDLE, and SHALL NOT change sel within a row.

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, set state IDLE, sel=0, sel_vld=0, row_done=0, frame_done=0, busy=0, counter=0, stop_pend=0, and clear the latched dwell and mask.
REQ-024 SHALL honour reset mid-row: outputs take reset values on the next cycle, no partial row_done or frame_done pulse occurs, and start is ignored while rst_n=0.

Configuration
REQ-025 SHALL support the macro SCAN_ROW_MASK_EN.
- Defined: the row_mask port exists and masked rows are skipped per REQ-017.
- Defined, all 8 bits set at start: the block stays IDLE.
- Defined, all 8 bits set at a frame boundary: the block enters IDLE as for stop.
- Undefined: the row_mask port is absent, all 8 rows are always enabled, and the frame is rows 0..7.

Verification
REQ-026 SHALL cover a basic scan: dwell=3, start pulse -> sel 0..7, 4 cycles each; row_done every 4th cycle; frame_done once per 32 cycles; wrap to 0.
REQ-027 SHALL cover the minimum dwell: dwell=0 -> sel changes every cycle, row_done constantly high, frame_done every 8th cycle.
REQ-028 SHALL cover a stop request: stop pulsed while sel=5 in its 2nd of 4 cycles -> row 5 completes, then sel=0, sel_vld=0, busy=0, with no frame_done.
REQ-029 SHALL cover masking (SCAN_ROW_MASK_EN): mask=8'b1010_1010 -> sel sequence 0,2,4,6,0; frame_done with row 6; mask=8'hFF with start -> stays IDLE.
REQ-030 SHALL cover reset mid-row: rst_n low for 1 cycle at sel=3 -> all outputs at reset values the next cycle; start then restarts from sel=0.
REQ-031 SHALL cover a dwell change mid-frame: dwell changed 3 to 1 mid-frame -> old dwell held to frame end, new dwell applied from the next frame's row 0.
